btn_conditioner: RTL

- Converts four raw, bouncing board pushbuttons (U, D, R, L) into the one-cycle movement command word that the player-rectangle movement stage consumes on its btns input.
- Sits directly upstream of that stage, in the same btnClk domain.
- Provides 2-FF synchronisation, per-button debounce, a single-direction priority select, and typematic auto-repeat while a button is held.
- The downstream stage moves exactly one step per nonzero btns cycle.

---
 rtl/btn_conditioner_pkg.sv | 31 +++
 rtl/btn_conditioner_if.sv | 23 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/btn_conditioner.sv | 94 +++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types for the pushbutton conditioner: direction codes,
// FSM states and the single-direction priority select.
package btn_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_e;

   localparam logic [3:0] DIR_U    = 4'd8;
   localparam logic [3:0] DIR_D    = 4'd4;
   localparam logic [3:0] DIR_R    = 4'd2;
   localparam logic [3:0] DIR_L    = 4'd1;
   localparam logic [3:0] DIR_NONE = 4'd0;

   // Bit order is [3]=U [2]=D [1]=R [0]=L; U has highest priority.
   function automatic logic [3:0] dir_sel(input logic [3:0] lvl);
      logic [3:0] s;
      s = DIR_NONE;
      priority case (1'b1)
         lvl[3]:  s = DIR_U;
         lvl[2]:  s = DIR_D;
         lvl[1]:  s = DIR_R;
         lvl[0]:  s = DIR_L;
         default: s = DIR_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-side bundle: raw inputs in, command word and levels out.
interface btn_conditioner_if;

   logic [3:0] btn_raw;
   logic [3:0] btns;
   logic [3:0] btn_level;
   logic       btn_active;

   modport master (
      output btn_raw,
      input  btns,
      input  btn_level,
      input  btn_active
   );

   modport slave (
      input  btn_raw,
      output btns,
      output btn_level,
      output btn_active
   );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser followed by a consecutive-cycle
// debounce counter that only moves the level after a stable run.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 26
) (
   input  logic btnClk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   logic             s1_q, s2_q;
   logic             level_d, level_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (s2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         level_d = s2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge btnClk or negedge rst) begin
      if (!rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= raw;
         s2_q    <= s1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Four debounced buttons -> one-hot single-cycle movement commands
// with a press pulse and typematic auto-repeat while held.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int CNT_W           = 26
) (
   input  logic               btnClk,
   input  logic               rst,
   btn_conditioner_if.slave   io
);

   logic [3:0]       lvl;
   logic [3:0]       sel;
   logic [CNT_W-1:0] limit;

   state_e           state_d, state_q;
   logic [3:0]       held_d, held_q;
   logic [3:0]       btns_d, btns_q;
   logic [CNT_W-1:0] timer_d, timer_q;

   for (genvar i = 0; i < 4; i++) begin : g_db
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .btnClk(btnClk),
         .rst   (rst),
         .raw   (io.btn_raw[i]),
         .level (lvl[i])
      );
   end

   assign sel   = dir_sel(lvl);
   assign limit = (state_q == HOLD) ? CNT_W'(HOLD_CYCLES - 1)
                                    : CNT_W'(REPEAT_CYCLES - 1);

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      timer_d = timer_q;
      btns_d  = DIR_NONE;
      unique case (state_q)
         IDLE: begin
            if (sel != DIR_NONE) begin
               btns_d  = sel;
               held_d  = sel;
               timer_d = '0;
               state_d = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (sel == DIR_NONE) begin
               state_d = IDLE;
            end else if (sel != held_q) begin
               // New direction wins immediately and restarts the hold.
               btns_d  = sel;
               held_d  = sel;
               timer_d = '0;
               state_d = HOLD;
            end else if (timer_q == limit) begin
               btns_d  = held_q;
               timer_d = '0;
               state_d = REPEAT;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge btnClk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         held_q  <= DIR_NONE;
         btns_q  <= DIR_NONE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         btns_q  <= btns_d;
         timer_q <= timer_d;
      end
   end

   assign io.btns       = btns_q;
   assign io.btn_level  = lvl;
   assign io.btn_active = (state_q != IDLE);

endmodule
